// File: rtl/stage3_hazard_scoreboard.sv
// stage3_hazard_scoreboard: register scoreboard for long-latency writers plus I-fetch redirect drain tracker
module stage3_hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int MAX_PENDING  = 4,
    parameter int MAX_IMEM_OUT = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_rs1,
    input  logic [REG_W-1:0]    issue_rs2,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic                issue_reg_write,
    input  logic                issue_long,
    output logic                issue_stall,
    input  logic                complete_valid,
    input  logic [REG_W-1:0]    complete_rd,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                sb_full,
    output logic                sb_err,
    input  logic                imem_req_fire,
    input  logic                imem_resp_valid,
    input  logic                redirect,
    output logic                fetch_hold,
    output logic                discard_resp,
    output logic                drain_active
);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int IW = $clog2(MAX_IMEM_OUT + 1);
    localparam int XW = 2 ** REG_W;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state;
    logic [PW-1:0]     pend_cnt;
    logic [IW-1:0]     imem_out;
    logic [IW-1:0]     stale_cnt;
    logic [IW-1:0]     imem_nxt;
    logic [XW-1:0]     pend_ext;
    logic [XW-1:0]     set_ext;
    logic [XW-1:0]     clr_ext;
    logic              raw;
    logic              waw;
    logic              accept;
    logic              cmp;
    logic              resp_ok;
    logic              fire_ok;

    assign raw          = (issue_rs1 != '0 && pend_ext[issue_rs1]) || (issue_rs2 != '0 && pend_ext[issue_rs2]);
    assign waw          = issue_reg_write && issue_rd != '0 && pend_ext[issue_rd];
    assign sb_full      = pend_cnt == PW'(MAX_PENDING);
    assign issue_stall  = issue_valid && (raw || waw || (issue_long && sb_full));
    assign accept       = issue_valid && !issue_stall && issue_long && issue_reg_write && issue_rd != '0;
    assign cmp          = complete_valid && pend_ext[complete_rd];
    assign fetch_hold   = imem_out == IW'(MAX_IMEM_OUT);
    assign resp_ok      = imem_resp_valid && imem_out != '0;
    assign fire_ok      = imem_req_fire && (!fetch_hold || resp_ok);
    assign imem_nxt     = imem_out + IW'(fire_ok) - IW'(resp_ok);
    assign discard_resp = imem_resp_valid && stale_cnt != '0;
    assign drain_active = state == DRAIN;

    // Widen the pending bits to the full index space and decode the set/clear one-hots
    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_REGS-1:0] = pending_mask;
        set_ext = '0;
        clr_ext = '0;
        set_ext[issue_rd] = accept;
        clr_ext[complete_rd] = cmp;
    end

    // Scoreboard, fetch counter and sticky error
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pending_mask <= '0;
            pend_cnt     <= '0;
            imem_out     <= '0;
            sb_err       <= 1'b0;
        end else begin
            pending_mask <= (pending_mask & ~clr_ext[NUM_REGS-1:0]) | set_ext[NUM_REGS-1:0];
            pend_cnt     <= pend_cnt + PW'(accept) - PW'(cmp);
            imem_out     <= imem_nxt;
            sb_err       <= sb_err || (complete_valid && !cmp) || (imem_resp_valid && imem_out == '0);
        end
    end

    // Redirect drain FSM: everything in flight after a redirect edge is stale
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= RUN;
            stale_cnt <= '0;
        end else if (redirect) begin
            stale_cnt <= imem_nxt;
            state     <= (imem_nxt != '0) ? DRAIN : RUN;
        end else if (discard_resp) begin
            stale_cnt <= stale_cnt - IW'(1);
            if (stale_cnt == IW'(1)) state <= RUN;
        end
    end
endmodule

// File: tb/tb_stage3_hazard_scoreboard.sv
// tb_stage3_hazard_scoreboard: directed self-checking bench for the hazard scoreboard and drain FSM
module tb_stage3_hazard_scoreboard;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        issue_valid, issue_reg_write, issue_long, issue_stall;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, complete_rd;
    logic        complete_valid;
    logic [31:0] pending_mask;
    logic        sb_full, sb_err;
    logic        imem_req_fire, imem_resp_valid, redirect;
    logic        fetch_hold, discard_resp, drain_active;
    int          checks = 0;
    int          errors = 0;

    stage3_hazard_scoreboard dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write), .issue_long(issue_long),
        .issue_stall(issue_stall), .complete_valid(complete_valid), .complete_rd(complete_rd),
        .pending_mask(pending_mask), .sb_full(sb_full), .sb_err(sb_err),
        .imem_req_fire(imem_req_fire), .imem_resp_valid(imem_resp_valid), .redirect(redirect),
        .fetch_hold(fetch_hold), .discard_resp(discard_resp), .drain_active(drain_active)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic lng, input logic rw, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = v; issue_long = lng; issue_reg_write = rw;
        issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    task automatic complete(input logic v, input logic [4:0] rd);
        complete_valid = v; complete_rd = rd;
    endtask

    initial begin
        nRST = 1'b0;
        issue(0, 0, 0, 0, 0, 0);
        complete(0, 0);
        imem_req_fire = 0; imem_resp_valid = 0; redirect = 0;
        tick(); tick();
        nRST = 1'b1;
        #1;
        chk("rst_mask", pending_mask, 0);
        chk("rst_full", sb_full, 0);
        chk("rst_err", sb_err, 0);
        chk("rst_hold", fetch_hold, 0);
        chk("rst_drain", drain_active, 0);
        chk("rst_stall", issue_stall, 0);
        chk("rst_discard", discard_resp, 0);

        // RAW on rd 5 with no same-cycle bypass
        issue(1, 1, 1, 5, 0, 0);
        #1 chk("raw_first_issue", issue_stall, 0);
        tick();
        chk("raw_mask5", pending_mask, 32'h20);
        issue(1, 0, 1, 8, 5, 0);
        #1 chk("raw_stall", issue_stall, 1);
        tick();
        complete(1, 5);
        #1 chk("raw_no_bypass", issue_stall, 1);
        tick();
        complete(0, 0);
        #1 chk("raw_release", issue_stall, 0);
        chk("raw_mask_clr", pending_mask, 0);
        issue(0, 0, 0, 0, 0, 0);

        // Fill scoreboard, structural stall, completion frees an entry
        for (int r = 1; r <= 4; r++) begin
            issue(1, 1, 1, 5'(r), 0, 0);
            tick();
        end
        chk("full_mask", pending_mask, 32'h1E);
        chk("full_flag", sb_full, 1);
        issue(1, 1, 1, 6, 0, 0);
        complete(1, 2);
        #1 chk("struct_stall", issue_stall, 1);
        tick();
        complete(0, 0);
        #1 chk("struct_release", issue_stall, 0);
        chk("struct_mask", pending_mask, 32'h1A);
        chk("struct_not_full", sb_full, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0);
        chk("refill_mask", pending_mask, 32'h5A);
        chk("refill_full", sb_full, 1);
        complete(1, 1); tick();
        chk("drain_one_full", sb_full, 0);
        complete(1, 3); tick();
        complete(1, 4); tick();
        complete(1, 6); tick();
        complete(0, 0);
        chk("empty_mask", pending_mask, 0);
        chk("no_err_yet", sb_err, 0);

        // Accept and complete in one cycle keep the count steady
        issue(1, 1, 1, 10, 0, 0); tick();
        issue(1, 1, 1, 11, 0, 0); complete(1, 10); tick();
        issue(0, 0, 0, 0, 0, 0); complete(0, 0);
        chk("acc_cmp_mask", pending_mask, 32'h800);
        for (int r = 12; r <= 14; r++) begin
            issue(1, 1, 1, 5'(r), 0, 0);
            tick();
        end
        issue(0, 0, 0, 0, 0, 0);
        chk("acc_cmp_full", sb_full, 1);
        for (int r = 11; r <= 14; r++) begin
            complete(1, 5'(r));
            tick();
        end
        complete(0, 0);
        chk("acc_cmp_empty", pending_mask, 0);

        // WAW and writes that take no entry
        issue(1, 1, 1, 7, 0, 0); tick();
        issue(1, 0, 1, 7, 0, 0);
        #1 chk("waw_stall", issue_stall, 1);
        issue(1, 1, 1, 0, 0, 0);
        #1 chk("rd0_no_stall", issue_stall, 0);
        tick();
        issue(1, 1, 0, 9, 0, 0);
        #1 chk("nowrite_no_stall", issue_stall, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0);
        chk("no_entry_mask", pending_mask, 32'h80);
        complete(1, 7); tick(); complete(0, 0);
        chk("waw_clear", pending_mask, 0);

        // Redirect with two requests in flight
        imem_req_fire = 1; tick();
        chk("one_out_hold", fetch_hold, 0);
        tick();
        imem_req_fire = 0;
        chk("two_out_hold", fetch_hold, 1);
        redirect = 1;
        #1 chk("redir_no_discard", discard_resp, 0);
        tick();
        redirect = 0;
        chk("drain_on", drain_active, 1);
        imem_resp_valid = 1;
        #1 chk("stale1", discard_resp, 1);
        tick();
        chk("stale2", discard_resp, 1);
        chk("still_drain", drain_active, 1);
        tick();
        imem_resp_valid = 0;
        chk("drain_done", drain_active, 0);
        chk("hold_free", fetch_hold, 0);
        imem_req_fire = 1; tick(); imem_req_fire = 0;
        imem_resp_valid = 1;
        #1 chk("fresh_kept", discard_resp, 0);
        tick();
        imem_resp_valid = 0;
        chk("fresh_run", drain_active, 0);
        chk("fetch_no_err", sb_err, 0);

        // Redirect inside DRAIN with a new request fired
        imem_req_fire = 1; tick(); tick(); imem_req_fire = 0;
        redirect = 1; tick(); redirect = 0;
        imem_resp_valid = 1; tick(); imem_resp_valid = 0;
        chk("mid_drain", drain_active, 1);
        redirect = 1; imem_req_fire = 1; tick(); redirect = 0; imem_req_fire = 0;
        imem_resp_valid = 1;
        #1 chk("redrain1", discard_resp, 1);
        tick();
        chk("redrain2", discard_resp, 1);
        chk("redrain_active", drain_active, 1);
        tick();
        imem_resp_valid = 0;
        chk("redrain_done", drain_active, 0);

        // Redirect with nothing in flight stays in RUN
        redirect = 1; tick(); redirect = 0;
        chk("idle_redirect", drain_active, 0);

        // Reset mid-drain with pending entries
        for (int r = 1; r <= 3; r++) begin
            issue(1, 1, 1, 5'(r), 0, 0);
            imem_req_fire = (r <= 2);
            tick();
        end
        issue(0, 0, 0, 0, 0, 0); imem_req_fire = 0;
        redirect = 1; tick(); redirect = 0;
        chk("pre_rst_drain", drain_active, 1);
        chk("pre_rst_mask", pending_mask, 32'hE);
        nRST = 0; imem_resp_valid = 1; complete(1, 1); tick();
        nRST = 1; imem_resp_valid = 0; complete(0, 0);
        chk("post_rst_mask", pending_mask, 0);
        chk("post_rst_drain", drain_active, 0);
        chk("post_rst_hold", fetch_hold, 0);
        chk("post_rst_err", sb_err, 0);
        complete(1, 3); tick(); complete(0, 0);
        chk("bad_cmp_err", sb_err, 1);
        chk("bad_cmp_mask", pending_mask, 0);
        chk("bad_cmp_full", sb_full, 0);
        tick();
        chk("err_sticky", sb_err, 1);

        // Orphan I-response sets the error and keeps the counter at zero
        nRST = 0; tick(); nRST = 1;
        imem_resp_valid = 1; tick(); imem_resp_valid = 0;
        chk("orphan_err", sb_err, 1);
        imem_req_fire = 1; tick(); tick(); imem_req_fire = 0;
        chk("orphan_no_underflow", fetch_hold, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
